// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multi-cycle load/store sequencer in front of a
// word-addressed data memory. It splits accesses that straddle a word
// boundary into two word accesses and waits out a fixed read latency.
// It also produces byte write enables and extends load data by load mode.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic [2:0]  req_load_type,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] WR0  = 3'd3;
  localparam logic [2:0] WR1  = 3'd4;
  localparam logic [2:0] RESP = 3'd5;

  // Wait counter compares against the latency; 4 bits cover 1..15.
  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [2:0]  state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  n_q;       // access width in bytes: 1, 2 or 4
  logic [2:0]  ltype_q;
  logic [31:0] lo_q;      // data read from word A
  logic [31:0] hi_q;      // data read from word B (zero when not split)
  logic [3:0]  cnt_q;     // cycles spent in the current read state

  logic [2:0]  req_n;
  logic        req_noop;
  logic [1:0]  off;
  logic [29:0] word_a;
  logic [29:0] word_b;
  logic        split;
  logic        rd_done;
  logic [3:0]  lane_mask;
  logic [63:0] wr_wide;
  logic [7:0]  we_wide;
  logic [63:0] rd_wide;
  logic [31:0] rd_shift;

  // Decode the incoming request into a byte count, or flag it as a no-op.
  // NOTE: every variable written here gets a default first, so no path
  // through the case statements can leave a latch behind.
  always_comb begin
    req_n    = 3'd0;
    req_noop = 1'b0;
    if (req_we) begin
      case (req_size)
        2'd0:    req_n = 3'd1;
        2'd1:    req_n = 3'd2;
        2'd2:    req_n = 3'd4;
        default: req_noop = 1'b1;
      endcase
    end else begin
      case (req_load_type)
        3'd1, 3'd4: req_n = 3'd1;
        3'd2, 3'd5: req_n = 3'd2;
        3'd3:       req_n = 3'd4;
        default:    req_noop = 1'b1;
      endcase
    end
  end

  assign off     = addr_q[1:0];
  assign word_a  = addr_q[31:2];
  assign word_b  = word_a + 30'd1;   // wraps 0x3FFFFFFF -> 0
  assign split   = (({2'b00, off} + {1'b0, n_q}) > 4'd4);
  assign rd_done = (cnt_q == LAT);

  // Byte-lane mask for the access width before it is shifted into place.
  always_comb begin
    case (n_q)
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  // Stores are shifted across a two-word window; the low word goes out in
  // WR0 and the high word in WR1. Loads are pulled back out of the same
  // window.
  assign wr_wide  = {32'b0, wdata_q} << {off, 3'b000};
  assign we_wide  = {4'b0000, lane_mask} << off;
  assign rd_wide  = {hi_q, lo_q};
  assign rd_shift = rd_wide[{off, 3'b000} +: 32];

  // Sequencer state, latched request and read capture buffers.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      n_q     <= '0;
      ltype_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
            n_q     <= req_n;
            ltype_q <= req_load_type;
            lo_q    <= '0;
            hi_q    <= '0;
            cnt_q   <= '0;
            if (req_noop)    state <= RESP;
            else if (req_we) state <= WR0;
            else             state <= RD0;
          end
        end
        RD0: begin
          if (rd_done) begin
            lo_q  <= mem_rdata;
            cnt_q <= '0;
            state <= split ? RD1 : RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RD1: begin
          if (rd_done) begin
            hi_q  <= mem_rdata;
            cnt_q <= '0;
            state <= RESP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WR0:     state <= split ? WR1 : RESP;
        WR1:     state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes and handshake outputs decoded from the current state.
  always_comb begin
    mem_addr  = '0;
    mem_re    = 1'b0;
    mem_we    = 4'b0000;
    mem_wdata = '0;
    case (state)
      RD0: begin
        mem_addr = word_a;
        mem_re   = (cnt_q == 4'd0);
      end
      RD1: begin
        mem_addr = word_b;
        mem_re   = (cnt_q == 4'd0);
      end
      WR0: begin
        mem_addr  = word_a;
        mem_we    = we_wide[3:0];
        mem_wdata = wr_wide[31:0];
      end
      WR1: begin
        mem_addr  = word_b;
        mem_we    = we_wide[7:4];
        mem_wdata = wr_wide[63:32];
      end
      default: ;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP);

  // Extended load result, only driven while responding to a real load.
  always_comb begin
    resp_rdata = '0;
    if (state == RESP && !we_q) begin
      case (ltype_q)
        3'd1:    resp_rdata = {{24{rd_shift[7]}}, rd_shift[7:0]};
        3'd2:    resp_rdata = {{16{rd_shift[15]}}, rd_shift[15:0]};
        3'd3:    resp_rdata = rd_shift;
        3'd4:    resp_rdata = {24'b0, rd_shift[7:0]};
        3'd5:    resp_rdata = {16'b0, rd_shift[15:0]};
        default: resp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: two instances (read latency 1 and 3) share
// the request inputs and one behavioural memory; directed vectors with
// hand-computed results plus a reset-during-split-store sequence.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [2:0]  req_load_type;

  logic        req_ready_a, resp_valid_a, busy_a, mem_re_a;
  logic [31:0] resp_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [29:0] mem_addr_a;
  logic [3:0]  mem_we_a;

  logic        req_ready_b, resp_valid_b, busy_b, mem_re_b;
  logic [31:0] resp_rdata_b, mem_wdata_b, mem_rdata_b;
  logic [29:0] mem_addr_b;
  logic [3:0]  mem_we_b;

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_load_type(req_load_type),
    .resp_valid(resp_valid_a), .resp_rdata(resp_rdata_a), .busy(busy_a),
    .mem_addr(mem_addr_a), .mem_re(mem_re_a), .mem_we(mem_we_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
  );

  mem_access_ctrl #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_load_type(req_load_type),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_re(mem_re_b), .mem_we(mem_we_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
  );

  // Shared word memory; a read strobe in cycle k yields data in cycle k+LAT,
  // and a poison value at any other time.
  logic [31:0] mem [logic [29:0]];
  logic [31:0] pipe_b1, pipe_b2;

  always @(posedge clk) begin
    mem_rdata_a <= (mem_re_a && mem.exists(mem_addr_a)) ? mem[mem_addr_a] : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    pipe_b1     <= (mem_re_b && mem.exists(mem_addr_b)) ? mem[mem_addr_b] : 32'hBAD0_BAD0;
    pipe_b2     <= pipe_b1;
    mem_rdata_b <= pipe_b2;
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [2:0]  ltype;
    logic [29:0] pa0;
    logic [31:0] pd0;
    logic [29:0] pa1;
    logic [31:0] pd1;
    logic [31:0] rdata;
    int          cyc1;
    int          cyc3;
    int          nrd;
    int          nwr;
    logic [29:0] wa0;
    logic [3:0]  we0;
    logic [31:0] wd0;
    logic [29:0] wa1;
    logic [3:0]  we1;
    logic [31:0] wd1;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  int          nresp[2], rcyc[2], nrd[2], nwr[2], ovl[2];
  logic [31:0] rdat[2];
  logic [29:0] ra[2][2];
  logic [29:0] wa[2][2];
  logic [3:0]  wm[2][2];
  logic [31:0] wd[2][2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Load entry: preload words pa0/pa1 (word A, word B) and expect reads of them.
  function automatic vec_t ld(logic [31:0] addr, logic [2:0] lt,
                              logic [29:0] pa0, logic [31:0] pd0,
                              logic [29:0] pa1, logic [31:0] pd1,
                              logic [31:0] rdata, int c1, int c3, int nr);
    vec_t v;
    v = '{we: 1'b0, addr: addr, wdata: 32'h0, size: 2'd0, ltype: lt,
          pa0: pa0, pd0: pd0, pa1: pa1, pd1: pd1, rdata: rdata,
          cyc1: c1, cyc3: c3, nrd: nr, nwr: 0,
          wa0: '0, we0: '0, wd0: '0, wa1: '0, we1: '0, wd1: '0};
    return v;
  endfunction

  function automatic vec_t st(logic [31:0] addr, logic [1:0] size, logic [31:0] wdata,
                              int c, int nw,
                              logic [29:0] wa0, logic [3:0] we0, logic [31:0] wd0,
                              logic [29:0] wa1, logic [3:0] we1, logic [31:0] wd1);
    vec_t v;
    v = '{we: 1'b1, addr: addr, wdata: wdata, size: size, ltype: 3'd0,
          pa0: 30'h0, pd0: 32'h0, pa1: 30'h1, pd1: 32'h0, rdata: 32'h0,
          cyc1: c, cyc3: c, nrd: 0, nwr: nw,
          wa0: wa0, we0: we0, wd0: wd0, wa1: wa1, we1: we1, wd1: wd1};
    return v;
  endfunction

  task automatic run_req(input int k, input vec_t v);
    int last;
    logic        s_rv[2], s_re[2];
    logic [31:0] s_rd[2], s_wd[2];
    logic [29:0] s_ad[2];
    logic [3:0]  s_we[2];
    mem[v.pa0] = v.pd0;
    mem[v.pa1] = v.pd1;
    last = ((v.cyc1 > v.cyc3) ? v.cyc1 : v.cyc3) + 3;
    @(negedge clk);
    check($sformatf("v%0d ready_before", k), {req_ready_b, req_ready_a}, 2'b11);
    req_valid     = 1'b1;
    req_we        = v.we;
    req_addr      = v.addr;
    req_wdata     = v.wdata;
    req_size      = v.size;
    req_load_type = v.ltype;
    @(posedge clk);
    #1;
    // Scramble the request lines; the latched copy must be what is used.
    req_valid     = 1'b0;
    req_we        = ~v.we;
    req_addr      = 32'hFFFF_FFFD;
    req_wdata     = 32'hFFFF_FFFF;
    req_size      = 2'd1;
    req_load_type = 3'd1;
    for (int i = 0; i < 2; i++) begin
      nresp[i] = 0; rcyc[i] = 0; nrd[i] = 0; nwr[i] = 0; ovl[i] = 0; rdat[i] = '0;
    end
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      s_rv[0] = resp_valid_a; s_rv[1] = resp_valid_b;
      s_re[0] = mem_re_a;     s_re[1] = mem_re_b;
      s_rd[0] = resp_rdata_a; s_rd[1] = resp_rdata_b;
      s_wd[0] = mem_wdata_a;  s_wd[1] = mem_wdata_b;
      s_ad[0] = mem_addr_a;   s_ad[1] = mem_addr_b;
      s_we[0] = mem_we_a;     s_we[1] = mem_we_b;
      for (int i = 0; i < 2; i++) begin
        if (s_rv[i]) begin
          if (nresp[i] == 0) begin
            rcyc[i] = c;
            rdat[i] = s_rd[i];
          end
          nresp[i]++;
        end
        if (s_re[i]) begin
          if (nrd[i] < 2) ra[i][nrd[i]] = s_ad[i];
          nrd[i]++;
        end
        if (s_we[i] != 4'b0000) begin
          if (nwr[i] < 2) begin
            wa[i][nwr[i]] = s_ad[i];
            wm[i][nwr[i]] = s_we[i];
            wd[i][nwr[i]] = s_wd[i];
          end
          nwr[i]++;
        end
        if (s_re[i] && s_we[i] != 4'b0000) ovl[i]++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      check($sformatf("v%0d.%0d resp_cycle", k, i), rcyc[i], (i == 0) ? v.cyc1 : v.cyc3);
      check($sformatf("v%0d.%0d resp_count", k, i), nresp[i], 1);
      check($sformatf("v%0d.%0d resp_rdata", k, i), rdat[i], v.rdata);
      check($sformatf("v%0d.%0d read_count", k, i), nrd[i], v.nrd);
      if (v.nrd > 0) check($sformatf("v%0d.%0d read_addr0", k, i), ra[i][0], v.pa0);
      if (v.nrd > 1) check($sformatf("v%0d.%0d read_addr1", k, i), ra[i][1], v.pa1);
      check($sformatf("v%0d.%0d write_count", k, i), nwr[i], v.nwr);
      if (v.nwr > 0) begin
        check($sformatf("v%0d.%0d wr0_addr", k, i), wa[i][0], v.wa0);
        check($sformatf("v%0d.%0d wr0_we", k, i), wm[i][0], v.we0);
        check($sformatf("v%0d.%0d wr0_data", k, i), wd[i][0], v.wd0);
      end
      if (v.nwr > 1) begin
        check($sformatf("v%0d.%0d wr1_addr", k, i), wa[i][1], v.wa1);
        check($sformatf("v%0d.%0d wr1_we", k, i), wm[i][1], v.we1);
        check($sformatf("v%0d.%0d wr1_data", k, i), wd[i][1], v.wd1);
      end
      check($sformatf("v%0d.%0d re_we_overlap", k, i), ovl[i], 0);
    end
    check($sformatf("v%0d busy_after", k), {busy_b, busy_a}, 2'b00);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_load_type = '0;

    // Loads: LW aligned, split LH/LHU/LW, LB/LBU, wrap-around, no-ops.
    vecs.push_back(ld(32'h100, 3'd3, 30'h40, 32'hDEADBEEF, 30'h41, 32'h0, 32'hDEADBEEF, 3, 5, 1));
    vecs.push_back(ld(32'h103, 3'd2, 30'h40, 32'h11223344, 30'h41, 32'h55667788, 32'hFFFF8811, 5, 9, 2));
    vecs.push_back(ld(32'h103, 3'd5, 30'h40, 32'h11223344, 30'h41, 32'h55667788, 32'h00008811, 5, 9, 2));
    vecs.push_back(ld(32'h101, 3'd3, 30'h40, 32'h11223344, 30'h41, 32'h55667788, 32'h88112233, 5, 9, 2));
    vecs.push_back(ld(32'h102, 3'd5, 30'h40, 32'h11223344, 30'h41, 32'h55667788, 32'h00001122, 3, 5, 1));
    vecs.push_back(ld(32'h201, 3'd1, 30'h80, 32'h00008000, 30'h81, 32'h0, 32'hFFFFFF80, 3, 5, 1));
    vecs.push_back(ld(32'h201, 3'd4, 30'h80, 32'h00008000, 30'h81, 32'h0, 32'h00000080, 3, 5, 1));
    vecs.push_back(ld(32'hFFFFFFFE, 3'd3, 30'h3FFFFFFF, 32'hCAFEF00D, 30'h0, 32'h01234567, 32'h4567CAFE, 5, 9, 2));
    vecs.push_back(ld(32'h100, 3'd0, 30'h40, 32'h11223344, 30'h41, 32'h55667788, 32'h0, 1, 1, 0));
    vecs.push_back(ld(32'h100, 3'd7, 30'h40, 32'h11223344, 30'h41, 32'h55667788, 32'h0, 1, 1, 0));
    // Stores: split SW, SB with junk upper bits, SH in-word, split SH, no-op size.
    vecs.push_back(st(32'h102, 2'd2, 32'hAABBCCDD, 3, 2,
                      30'h40, 4'b1100, 32'hCCDD0000, 30'h41, 4'b0011, 32'h0000AABB));
    vecs.push_back(st(32'h103, 2'd0, 32'h1234565A, 2, 1,
                      30'h40, 4'b1000, 32'h5A000000, 30'h0, 4'b0000, 32'h0));
    vecs.push_back(st(32'h101, 2'd1, 32'h1234BEEF, 2, 1,
                      30'h40, 4'b0110, 32'h34BEEF00, 30'h0, 4'b0000, 32'h0));
    vecs.push_back(st(32'h103, 2'd1, 32'h0000BEEF, 3, 2,
                      30'h40, 4'b1000, 32'hEF000000, 30'h41, 4'b0001, 32'h000000BE));
    vecs.push_back(st(32'h100, 2'd3, 32'hFFFFFFFF, 1, 0,
                      30'h0, 4'b0000, 32'h0, 30'h0, 4'b0000, 32'h0));

    // Reset values.
    repeat (2) @(negedge clk);
    check("reset_ready", {req_ready_b, req_ready_a}, 2'b11);
    check("reset_busy", {busy_b, busy_a}, 2'b00);
    check("reset_strobes", {mem_re_b, mem_we_b, mem_re_a, mem_we_a}, 10'h0);
    check("reset_resp", {resp_valid_b, resp_rdata_b, resp_valid_a, resp_rdata_a}, 66'h0);
    check("reset_mem_addr", {mem_addr_b, mem_addr_a}, 60'h0);
    check("reset_mem_wdata", {mem_wdata_b, mem_wdata_a}, 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) run_req(k, vecs[k]);

    // Reset in the middle of a split store: WR1 must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h102;
    req_wdata = 32'hAABBCCDD; req_size = 2'd2; req_load_type = 3'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_wr0_we", {mem_we_b, mem_we_a}, 8'b1100_1100);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", {mem_we_b, mem_we_a}, 8'h00);
    check("rst_mid_ready", {req_ready_b, req_ready_a}, 2'b11);
    check("rst_mid_busy", {busy_b, busy_a}, 2'b00);
    check("rst_mid_resp", {resp_valid_b, resp_valid_a}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_we_a != 4'b0000 || mem_we_b != 4'b0000 || mem_re_a || mem_re_b ||
          resp_valid_a || resp_valid_b) bad++;
    end
    check("rst_after_quiet", bad, 0);
    run_req(100, ld(32'h104, 3'd3, 30'h41, 32'h55667788, 30'h42, 32'h0, 32'h55667788, 3, 5, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
